// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EXE stage: shift-add multiply and
// restoring divide, one bit per cycle, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// MUL   | shift-add iterations on the 2*WIDTH accumulator
// DIV   | restoring-division iterations, one quotient bit per cycle
// FIX   | sign correction, register HI/LO, pulse done
module alu_muldiv #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state;
    logic                 s1, s2, is_div, dz;
    logic [WIDTH-1:0]     a_mag, b_mag, num1_q, rem;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    logic                 sgn_op, div_ge;
    logic [WIDTH-1:0]     mag1, mag2, div_diff, quo_fix, rem_fix;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic [2*WIDTH-1:0]   prod_fix;

    always_comb begin
        sgn_op    = ~op[0];
        mag1      = (sgn_op && num1[WIDTH-1]) ? -num1 : num1;
        mag2      = (sgn_op && num2[WIDTH-1]) ? -num2 : num2;
        // Carry out of the upper half is kept so full-range unsigned operands work
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_mag};
        // True difference is below the divisor, so WIDTH bits are enough
        div_diff  = div_shift[WIDTH-1:0] - b_mag;
        prod_fix  = (s1 ^ s2) ? -acc : acc;
        quo_fix   = (s1 ^ s2) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = s1 ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            a_mag       <= '0;
            b_mag       <= '0;
            num1_q      <= '0;
            rem         <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            is_div      <= op[1];
                            s1          <= sgn_op & num1[WIDTH-1];
                            s2          <= sgn_op & num2[WIDTH-1];
                            a_mag       <= mag1;
                            b_mag       <= mag2;
                            num1_q      <= num1;
                            rem         <= '0;
                            acc         <= op[1] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
                            cnt         <= CNT_W'(WIDTH);
                            dz          <= op[1] && (num2 == '0);
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            if (!op[1])
                                state <= MUL;
                            else if (num2 == '0)
                                state <= FIX;
                            else
                                state <= DIV;
                        end
                    end
                    MUL: begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= FIX;
                    end
                    DIV: begin
                        rem             <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
                        cnt             <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= FIX;
                    end
                    FIX: begin
                        if (dz) begin
                            result_hi <= num1_q;
                            result_lo <= '1;
                        end else if (is_div) begin
                            result_hi <= rem_fix;
                            result_lo <= quo_fix;
                        end else begin
                            {result_hi, result_lo} <= prod_fix;
                        end
                        div_by_zero <= dz;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk, rst, start, flush;
    logic [1:0]   op;
    logic [W-1:0] num1, num2;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_hi, result_lo;

    int vectors = 0;
    int miscompares = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
        .flush(flush), .busy(busy), .done(done), .result_hi(result_hi),
        .result_lo(result_lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference built from the arithmetic meaning of each opcode
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, b,
                         output logic [W-1:0] hi, lo, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (o)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    dz = 1'b1; hi = a; lo = '1;
                end else if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    hi = r[31:0]; lo = q[31:0];
                end else begin
                    hi = a % b; lo = a / b;
                end
            end
        endcase
    endtask

    // Drives start immediately, so calling it straight after a done sample
    // issues a back-to-back launch in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, b,
                          output logic [W-1:0] hi, lo, output logic dz, output int lat);
        bit busy_bad;
        busy_bad = 0;
        start = 1'b1; op = o; num1 = a; num2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        if (busy !== 1'b1) busy_bad = 1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1;
        end
        hi = result_hi; lo = result_lo; dz = div_by_zero;
        check("busy_while_running", 64'(busy_bad), 64'd0);
        check("busy_at_done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0] hi, lo, ehi, elo, a, b;
        logic         dz, edz;
        int           lat;
        bit           done_seen;
        logic [1:0]   o;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; num1 = '0; num2 = '0;

        vt[0] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        vt[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vt[2] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        vt[3] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vt[4] = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
        vt[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vt[6] = '{2'd3, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1};
        vt[7] = '{2'd1, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0, 33};
        vt[8] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1};
        vt[9] = '{2'd3, 32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA, 1'b0, 33};

        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz", 64'(div_by_zero), 64'd0);
        check("reset_hi", 64'(result_hi), 64'd0);
        check("reset_lo", 64'(result_lo), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Table runs back-to-back: each launch happens in the previous done cycle
        foreach (vt[i]) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, hi, lo, dz, lat);
            check("tbl_hi", 64'(hi), 64'(vt[i].hi));
            check("tbl_lo", 64'(lo), 64'(vt[i].lo));
            check("tbl_dz", 64'(dz), 64'(vt[i].dz));
            check("tbl_latency", 64'(lat), 64'(vt[i].lat));
        end

        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 64'(done), 64'd0);
        check("hold_hi", 64'(result_hi), 64'(vt[9].hi));
        check("hold_lo", 64'(result_lo), 64'(vt[9].lo));

        // Start while busy is ignored
        start = 1'b1; op = 2'd1; num1 = 32'd1000; num2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            start = (n == 10);
            if (n == 10) begin op = 2'd3; num1 = 32'd5; num2 = 32'd0; end
        end
        start = 1'b0;
        check("ignore_latency", 64'(lat), 64'd33);
        check("ignore_hi", 64'(result_hi), 64'd0);
        check("ignore_lo", 64'(result_lo), 64'd3000);
        check("ignore_dz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        check("ignore_no_relaunch", 64'(busy), 64'd0);

        // Flush mid-multiply, with an ignored start before it
        done_seen = 0;
        start = 1'b1; op = 2'd0; num1 = 32'd7; num2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen = 1;
            start = (n == 9);
            flush = (n == 11);
            if (n == 9) begin op = 2'd2; num1 = 32'd100; num2 = 32'd0; end
        end
        check("flush_busy", 64'(busy), 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen = 1;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_hi", 64'(result_hi), 64'd0);
        check("flush_lo", 64'(result_lo), 64'd3000);

        // Flush and start together in IDLE launches nothing
        done_seen = 0;
        start = 1'b1; flush = 1'b1; op = 2'd1; num1 = 32'd2; num2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen = 1;
        end
        check("flush_start_no_done", 64'(done_seen), 64'd0);
        check("flush_start_lo", 64'(result_lo), 64'd3000);

        // Asynchronous reset in the middle of a divide
        start = 1'b1; op = 2'd2; num1 = 32'd1000; num2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_dz", 64'(div_by_zero), 64'd0);
        check("midrst_hi", 64'(result_hi), 64'd0);
        check("midrst_lo", 64'(result_lo), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Randomized operations, biased toward the boundary operands
        for (int i = 0; i < 200; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2: a = 32'h80000000;
                3: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(0, 20)); end
                4: a = '1;
                default: ;
            endcase
            model(o, a, b, ehi, elo, edz);
            run_op(o, a, b, hi, lo, dz, lat);
            check("rnd_hi", 64'(hi), 64'(ehi));
            check("rnd_lo", 64'(lo), 64'(elo));
            check("rnd_dz", 64'(dz), 64'(edz));
            check("rnd_latency", 64'(lat), edz ? 64'd1 : 64'd33);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide unit for the MIPS EXE stage. Implements MULT, MULTU, DIV and DIVU and produces HI/LO results.
- Generalises the single-cycle combinational ALU to a parametrised, multi-cycle datapath with a start/busy/done handshake.
- The pipeline stalls on busy and writes HI/LO on the done pulse.

Parameters:
- WIDTH, 32, operand width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  launch request; sampled only in IDLE
- op  in  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
- num1  in  WIDTH  rs operand (multiplicand / dividend)
- num2  in  WIDTH  rt operand (multiplier / divisor)
- flush  in  1  abort in-flight operation (exception/branch flush)
- busy  out  1  high while an operation is in flight; pipeline stall request
- done  out  1  one-cycle pulse when result_hi/result_lo update
- result_hi  out  WIDTH  HI: product upper half / remainder
- result_lo  out  WIDTH  LO: product lower half / quotient
- div_by_zero  out  1  valid with done; high if a DIV/DIVU had num2==0

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0.
  - result_hi=0, result_lo=0.
  - All internal registers cleared.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1:
  - Capture num1, num2 and op.
  - For signed ops, capture the operand signs and the magnitudes |num1| and |num2|. Unsigned ops use the raw values.
  - Counter is loaded with WIDTH.
  - Next state is MUL, or DIV. DIV with num2==0 goes to FIX directly and sets the zero flag.
  - busy goes high on the cycle after start.
- MUL: radix-2 shift-add, one bit per cycle on a 2*WIDTH accumulator. After WIDTH iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder. After WIDTH iterations go to FIX.
- FIX: sign correction.
  - Product is negated if s1^s2 (signed MULT).
  - Quotient is negated if s1^s2. Remainder is negated if s1, so the remainder takes the sign of the dividend (signed DIV).
  - Register results to result_hi/result_lo, assert done for exactly 1 cycle, drop busy, return to IDLE.
- Latency: start sampled at edge 0 → done high after edge WIDTH+1 (33 cycles for WIDTH=32). A new start is accepted in the cycle done is high.
- Divide by zero:
  - No iterations; done after edge 1.
  - result_lo = all ones, result_hi = num1 unchanged, div_by_zero=1.
  - div_by_zero clears on the next start.
- Most-negative / −1 (signed DIV): quotient = 1 followed by WIDTH−1 zeros (wraps), remainder=0, no flag.
- MULTU/DIVU with MSB-set operands are treated as full-range unsigned. A WIDTH+1-bit internal path is required.
- start while busy: ignored; captured operands are unaffected.
- flush:
  - Any state goes to IDLE on the next edge, with busy=0 and no done pulse.
  - result_hi/result_lo keep their previous values.
  - flush and start together in IDLE: flush wins, nothing launched.
- Outputs hold their values between done pulses.
- Reset mid-operation clears everything immediately; no done pulse.

Test Plan:
- MULT num1=FFFFFFFD (−3), num2=00000005 → done at cycle 33; HI=FFFFFFFF, LO=FFFFFFF1; busy high cycles 1–32.
- MULTU FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001; MULT of the same operands → HI=00000000, LO=00000001.
- DIV FFFFFFF9 (−7) / 00000002 → LO=FFFFFFFD, HI=FFFFFFFF; DIVU 00000064/00000007 → LO=0000000E, HI=00000002; DIV 80000000/FFFFFFFF → LO=80000000, HI=0.
- DIVU 12345678/00000000 → done at cycle 1, div_by_zero=1, LO=FFFFFFFF, HI=12345678; the next valid op clears div_by_zero.
- Start MULT; at cycle 10 assert start with new operands (ignored), then flush at cycle 12 → busy=0 at cycle 13, no done, HI/LO unchanged from the previous result.
- Assert rst at cycle 5 of a DIV → all outputs 0 immediately. Run back-to-back ops with start in the done cycle → second result correct at 33 cycles later. Repeat with WIDTH=16 and random signed/unsigned vectors against a reference model.
